mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Pipeline MEM stage that sits directly downstream of the execute stage and feeds write-back. It performs byte/half/word data-memory loads and stores over a req/ack handshake and stalls the pipeline while the memory is busy. It aligns and extends load data, detects misaligned accesses, and registers all results into the MEM/WB pipeline register. It also supplies the MEM-stage forwarding value back to execute.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: cycles in WAIT before a bus error is declared (only used with the timeout macro).

Ports:
- clk  in  1  pipeline clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  EX/MEM register holds a live instruction.
- alu_result  in  32  address for loads/stores; result for ALU ops.
- rs2  in  32  forwarded store data.
- memWrite / memRead2 / regWrite  in  1 each  control from EX.
- rf_wr_sel  in  2  write-back source select, passed through.
- wa  in  5  destination register.
- size  in  2  0=byte, 1=half, 2=word (3 treated as word).
- sign  in  1  1=zero-extend load (unsigned), 0=sign-extend.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1=store.
- dmem_addr  out  32  {alu_result[31:2], 2'b00}.
- dmem_be  out  4  byte enables (stores; 4'hF on loads).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  request accepted/complete; rdata valid the same cycle.
- dmem_rdata  in  32  raw word read.
- stall_mem  out  1  hold PC, IF/ID, ID/EX, EX/MEM this cycle.
- mem_wd  out  32  forwarding value = alu_result (combinational).
- misalign  out  1  one-cycle pulse on misaligned access.
- bus_err  out  1  one-cycle pulse on timeout (macro only, else 0).
- wb_valid, wb_regWrite  out  1  MEM/WB register.
- wb_wa  out  5; wb_rf_wr_sel  out  2; wb_alu_result  out  32; wb_load_data  out  32.

## Operation
- Access = in_valid & (memRead2 | memWrite); memWrite has priority if both are set.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. No dmem_req is issued. misalign pulses high. The instruction retires with wb_regWrite=0.
- FSM states IDLE, WAIT:
  - IDLE: aligned access drives dmem_req=1 combinationally.
    - With ack the same cycle: access completes, no stall, stay in IDLE.
    - Without ack: stall_mem=1 and go to WAIT.
  - WAIT: dmem_req held, with addr/we/be/wdata unchanged (upstream frozen by stall). stall_mem = !dmem_ack. On ack: complete and return to IDLE.
- Store lanes (o=addr[1:0]):
  - byte: be=4'b0001<<o, wdata={4{rs2[7:0]}}.
  - half: be=4'b0011<<o, wdata={2{rs2[15:0]}}.
  - word: be=4'hF, wdata=rs2.
- Load data: shifted = dmem_rdata >> (8*o). Byte or half is then zero- or sign-extended per sign; word is taken unchanged.
- MEM/WB register:
  - Loads on every cycle where stall_mem=0: wb_valid=in_valid, then regWrite/wa/rf_wr_sel/alu_result/load data.
  - While stall_mem=1: loads a bubble (wb_valid=0, wb_regWrite=0). Other wb fields hold.
- Non-memory instructions pass through in one cycle with no dmem_req.

## Timing
- Reset (rst_n=0 at clk edge): FSM=IDLE; wb_valid, wb_regWrite, wb_wa, wb_rf_wr_sel, wb_alu_result, wb_load_data all 0.
- During reset: dmem_req, stall_mem, misalign, bus_err = 0 (combinational outputs gated by !rst_n).
- Reset while in WAIT aborts the access. The dropped request is not retried.
- Latency EX/MEM->MEM/WB is 1 cycle with zero-wait ack, or 1+N cycles for N wait cycles.
- Every completed instruction produces exactly one wb_valid=1 cycle.
- dmem_ack while dmem_req=0 is ignored.
- in_valid=0 produces no request regardless of memRead2/memWrite.

## Configuration
- MEM_ACCESS_TIMEOUT_EN defined:
  - 5-bit wait counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without ack: bus_err pulses, dmem_req drops, and the FSM returns to IDLE. The instruction retires with wb_regWrite=0 and stall_mem=0 that cycle.
  - An ack on the same cycle as the timeout wins (normal completion).
- Not defined: no counter; WAIT lasts indefinitely; bus_err tied 0.

## Test plan
- Store byte: alu_result=0x1002, rs2=0xA5, size=0, ack same cycle -> dmem_addr=0x1000, be=4'b0100, wdata=0xA5A5A5A5, stall_mem=0, wb_regWrite=0.
- Load half signed: addr=0x2002, rdata=0x8001_1234, sign=0, ack after 3 wait cycles -> stall_mem high 3 cycles, 3 bubbles, then wb_load_data=0xFFFF8001, wb_valid=1 once.
- Load byte unsigned: addr=0x3003, rdata=0xF0000000, sign=1 -> wb_load_data=0x000000F0.
- Misaligned word load at 0x4001 -> no dmem_req, misalign=1 for 1 cycle, wb_valid=1, wb_regWrite=0.
- rst_n=0 during WAIT -> next cycle dmem_req=0, stall_mem=0, all wb outputs 0, FSM IDLE.
- With MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack never arrives -> bus_err pulses on the 16th WAIT cycle, then stall_mem=0 and wb_regWrite=0.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory req/ack bus between the MEM stage and data memory.
//   master (MEM stage): drives dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata
//   slave  (memory)   : drives dmem_ack, dmem_rdata (rdata valid in the ack cycle)
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  modport master (output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                  input  dmem_ack, dmem_rdata);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                  output dmem_ack, dmem_rdata);
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage doing byte/half/word loads and stores over a req/ack bus.
//   clk, rst_n (sync, active-low)
//   EX/MEM in : in_valid, alu_result, rs2, memWrite, memRead2, regWrite, rf_wr_sel, wa, size, sign
//   dmem      : mem_access_stage_if.master (req/we/addr/be/wdata out, ack/rdata in)
//   hazard out: stall_mem, mem_wd (forwarding), misalign, bus_err
//   MEM/WB out: wb_valid, wb_regWrite, wb_wa, wb_rf_wr_sel, wb_alu_result, wb_load_data
//   Optional macro MEM_ACCESS_TIMEOUT_EN: WAIT gives up after TIMEOUT_CYCLES and pulses bus_err.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        rs2,
  input  logic               memWrite,
  input  logic               memRead2,
  input  logic               regWrite,
  input  logic [1:0]         rf_wr_sel,
  input  logic [4:0]         wa,
  input  logic [1:0]         size,
  input  logic               sign,
  mem_access_stage_if.master dmem,
  output logic               stall_mem,
  output logic [31:0]        mem_wd,
  output logic               misalign,
  output logic               bus_err,
  output logic               wb_valid,
  output logic               wb_regWrite,
  output logic [4:0]         wb_wa,
  output logic [1:0]         wb_rf_wr_sel,
  output logic [31:0]        wb_alu_result,
  output logic [31:0]        wb_load_data
);
  typedef enum logic {IDLE, WAIT} state_e;
  state_e      state_q, state_d;
  logic [1:0]  o;
  logic        is_byte, is_half, access, mis, req, ack, tmo;
  logic [31:0] sh, ld;
  logic        wb_valid_q, wb_valid_d, wb_regWrite_q, wb_regWrite_d;
  logic [4:0]  wb_wa_q, wb_wa_d;
  logic [1:0]  wb_rf_wr_sel_q, wb_rf_wr_sel_d;
  logic [31:0] wb_alu_result_q, wb_alu_result_d, wb_load_data_q, wb_load_data_d;
  assign o       = alu_result[1:0];
  assign is_byte = size == 2'd0;
  assign is_half = size == 2'd1;
  assign access  = in_valid & (memRead2 | memWrite);
  assign mis     = access & (is_half ? o[0] : (!is_byte & |o));
  // WAIT keeps the request up by itself; upstream is frozen so the bus fields do not move
  assign req     = rst_n & ((state_q == WAIT) | (access & !mis));
  assign ack     = req & dmem.dmem_ack;
  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = memWrite;
  assign dmem.dmem_addr  = {alu_result[31:2], 2'b00};
  assign dmem.dmem_be    = !memWrite ? 4'hF : is_byte ? 4'b0001 << o : is_half ? 4'b0011 << o : 4'hF;
  assign dmem.dmem_wdata = is_byte ? {4{rs2[7:0]}} : is_half ? {2{rs2[15:0]}} : rs2;
  // sign=1 selects zero-extension, so the fill bit is the msb only for signed loads
  assign sh = dmem.dmem_rdata >> {o, 3'b000};
  assign ld = is_byte ? {{24{!sign & sh[7]}}, sh[7:0]} :
              is_half ? {{16{!sign & sh[15]}}, sh[15:0]} : dmem.dmem_rdata;
  assign mem_wd   = alu_result;
  assign misalign = rst_n & mis;
  assign bus_err  = tmo;
`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [4:0] cnt_q, cnt_d;
  // cnt_q holds the number of WAIT cycles already spent before the current one
  assign cnt_d = (state_q == WAIT) ? cnt_q + 5'd1 : 5'd0;
  assign tmo   = req & (state_q == WAIT) & (cnt_q == 5'(TIMEOUT_CYCLES - 1)) & !dmem.dmem_ack;
  always_ff @(posedge clk) cnt_q <= !rst_n ? 5'd0 : cnt_d;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    stall_mem = req & !ack & !tmo;
    state_d   = stall_mem ? WAIT : IDLE;
  end
  always_comb begin
    wb_valid_d      = in_valid & !stall_mem;
    wb_regWrite_d   = in_valid & !stall_mem & regWrite & !mis & !tmo;
    wb_wa_d         = stall_mem ? wb_wa_q : wa;
    wb_rf_wr_sel_d  = stall_mem ? wb_rf_wr_sel_q : rf_wr_sel;
    wb_alu_result_d = stall_mem ? wb_alu_result_q : alu_result;
    wb_load_data_d  = stall_mem ? wb_load_data_q : ld;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      wb_valid_q      <= 1'b0;
      wb_regWrite_q   <= 1'b0;
      wb_wa_q         <= '0;
      wb_rf_wr_sel_q  <= '0;
      wb_alu_result_q <= '0;
      wb_load_data_q  <= '0;
    end else begin
      state_q         <= state_d;
      wb_valid_q      <= wb_valid_d;
      wb_regWrite_q   <= wb_regWrite_d;
      wb_wa_q         <= wb_wa_d;
      wb_rf_wr_sel_q  <= wb_rf_wr_sel_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_load_data_q  <= wb_load_data_d;
    end
  end
  assign wb_valid      = wb_valid_q;
  assign wb_regWrite   = wb_regWrite_q;
  assign wb_wa         = wb_wa_q;
  assign wb_rf_wr_sel  = wb_rf_wr_sel_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_load_data  = wb_load_data_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized scoreboard bench for mem_access_stage with a memory responder model.
module tb_mem_access_stage;
  localparam int TMO = 16;
  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, memWrite, memRead2, regWrite, sign;
  logic [31:0] alu_result, rs2;
  logic [1:0] rf_wr_sel, size;
  logic [4:0] wa;
  logic stall_mem, misalign, bus_err, wb_valid, wb_regWrite;
  logic [31:0] mem_wd, wb_alu_result, wb_load_data;
  logic [4:0] wb_wa;
  logic [1:0] wb_rf_wr_sel;
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    int          waits;
  } req_t;
  typedef struct {
    logic [4:0]  wa;
    bit          rw;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] ld;
    bit          chk_ld;
  } wb_t;
  req_t rq[$];
  wb_t  wq[$];
  int n_chk = 0;
  int n_fail = 0;
  int sl_cnt = 0;

  mem_access_stage_if dmem();

  mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_result(alu_result), .rs2(rs2),
    .memWrite(memWrite), .memRead2(memRead2), .regWrite(regWrite), .rf_wr_sel(rf_wr_sel),
    .wa(wa), .size(size), .sign(sign), .dmem(dmem), .stall_mem(stall_mem), .mem_wd(mem_wd),
    .misalign(misalign), .bus_err(bus_err), .wb_valid(wb_valid), .wb_regWrite(wb_regWrite),
    .wb_wa(wb_wa), .wb_rf_wr_sel(wb_rf_wr_sel), .wb_alu_result(wb_alu_result),
    .wb_load_data(wb_load_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // memory responder: checks each request cycle against the pending item, acks after its wait count;
  // with no request it sometimes raises a stray ack that must be ignored
  always @(negedge clk) begin
    if (!rst_n) sl_cnt = 0;
    else if (dmem.dmem_req) begin
      if (rq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_req: addr %h with nothing pending", dmem.dmem_addr);
      end else begin
        chk("dmem_we", dmem.dmem_we, rq[0].we);
        chk("dmem_addr", dmem.dmem_addr, rq[0].addr);
        chk("dmem_be", dmem.dmem_be, rq[0].be);
        if (rq[0].we) chk("dmem_wdata", dmem.dmem_wdata, rq[0].wdata);
        if (sl_cnt == rq[0].waits) begin
          dmem.dmem_rdata = rq[0].rdata;
          dmem.dmem_ack = 1'b1;
          rq.delete(0);
          sl_cnt = 0;
        end else sl_cnt++;
      end
    end else begin
      dmem.dmem_rdata = $urandom;
      dmem.dmem_ack = ($urandom_range(0, 3) == 0);
    end
    if (dmem.dmem_ack) begin
      #6;
      dmem.dmem_ack = 1'b0;
    end
  end

  // write-back monitor
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (wq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wb_unexpected: wb_valid=1 alu %h with nothing expected", wb_alu_result);
      end else begin
        chk("wb_wa", wb_wa, wq[0].wa);
        chk("wb_regWrite", wb_regWrite, wq[0].rw);
        chk("wb_rf_wr_sel", wb_rf_wr_sel, wq[0].sel);
        chk("wb_alu_result", wb_alu_result, wq[0].alu);
        if (wq[0].chk_ld) chk("wb_load_data", wb_load_data, wq[0].ld);
        wq.delete(0);
      end
    end
  end

  task automatic issue(input bit v, input bit rd, input bit wr, input bit rw, input logic [1:0] sz,
                       input bit sg, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rdat, input int waits);
    logic [4:0] w;
    logic [1:0] sl;
    bit acc, mis, go, tmo, st, berr;
    int o, nb, sc, k;
    longint val;
    req_t r;
    wb_t e;
    w = 5'($urandom);
    sl = 2'($urandom);
    acc = v && (rd || wr);
    o = int'(a % 32'd4);
    nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    mis = acc && (o % nb != 0);
    go = acc && !mis;
    tmo = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
    tmo = go && waits > TMO;
`endif
    val = (longint'(rdat) >> (8 * o)) % (longint'(1) << (8 * nb));
    if (nb < 4 && !sg && val >= (longint'(1) << (8 * nb - 1))) val = val - (longint'(1) << (8 * nb));
    if (go) begin
      r.we = wr;
      r.addr = a - 32'(o);
      r.be = wr ? 4'(((1 << nb) - 1) << o) : 4'hF;
      r.wdata = (nb == 1) ? d[7:0] * 32'h01010101 : (nb == 2) ? d[15:0] * 32'h00010001 : d;
      r.rdata = rdat;
      r.waits = waits;
      rq.push_back(r);
    end
    if (v) begin
      e.wa = w;
      e.rw = rw && !mis && !tmo;
      e.sel = sl;
      e.alu = a;
      e.ld = 32'(val);
      e.chk_ld = go && !wr && !tmo;
      wq.push_back(e);
    end
    in_valid = v; memRead2 = rd; memWrite = wr; regWrite = rw; size = sz; sign = sg;
    alu_result = a; rs2 = d; wa = w; rf_wr_sel = sl;
    sc = 0;
    berr = 1'b0;
    for (k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (k == 0) begin
        chk("misalign", misalign, mis);
        chk("dmem_req", dmem.dmem_req, go);
        chk("mem_wd", mem_wd, a);
      end
      st = stall_mem;
      berr = bus_err;
      @(posedge clk); #2;
      if (!st) break;
      sc++;
    end
    if (k == 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL stall_bound: stall_mem still high after %0d cycles, limit 100", k);
    end
    chk("stall_cycles", sc, go ? (tmo ? TMO : waits) : 0);
    chk("bus_err", berr, tmo);
    if (tmo) begin
      rq.delete();
      sl_cnt = 0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dmem.dmem_ack = 1'b0;
    dmem.dmem_rdata = '0;
    rst_n = 1'b0;
    in_valid = 1'b1; memRead2 = 1'b1; memWrite = 1'b0; regWrite = 1'b1; size = 2'd2; sign = 1'b0;
    alu_result = 32'h4001; rs2 = '0; rf_wr_sel = '0; wa = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_misalign", misalign, 0);
    alu_result = 32'h4000;
    #1;
    chk("rst_req", dmem.dmem_req, 0);
    chk("rst_stall", stall_mem, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_regWrite", wb_regWrite, 0);
    chk("rst_wb_wa", wb_wa, 0);
    chk("rst_wb_sel", wb_rf_wr_sel, 0);
    chk("rst_wb_alu", wb_alu_result, 0);
    chk("rst_wb_ld", wb_load_data, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    issue(1, 0, 1, 0, 0, 0, 32'h1002, 32'h000000A5, $urandom, 0);
    issue(1, 1, 0, 1, 1, 0, 32'h2002, $urandom, 32'h80011234, 3);
    issue(1, 1, 0, 1, 0, 1, 32'h3003, $urandom, 32'hF0000000, 1);
    issue(1, 1, 0, 1, 2, 0, 32'h4001, $urandom, $urandom, 0);
    // reset while the memory keeps the access waiting
    begin
      req_t r;
      r.we = 1'b0; r.addr = 32'h5000; r.be = 4'hF; r.wdata = '0; r.rdata = '0; r.waits = 50;
      rq.push_back(r);
      in_valid = 1'b1; memRead2 = 1'b1; memWrite = 1'b0; regWrite = 1'b1; size = 2'd2; alu_result = 32'h5000;
      repeat (3) begin
        @(negedge clk); #1;
        chk("wait_stall", stall_mem, 1);
        @(posedge clk); #2;
      end
      rst_n = 1'b0;
      @(negedge clk); #1;
      chk("rst_wait_req", dmem.dmem_req, 0);
      chk("rst_wait_stall", stall_mem, 0);
      @(posedge clk); #2;
      chk("rst_wait_wb_valid", wb_valid, 0);
      chk("rst_wait_wb_regWrite", wb_regWrite, 0);
      chk("rst_wait_wb_alu", wb_alu_result, 0);
      chk("rst_wait_wb_wa", wb_wa, 0);
      chk("rst_wait_wb_ld", wb_load_data, 0);
      rst_n = 1'b1;
      in_valid = 1'b0;
      rq.delete();
      @(negedge clk); #1;
      chk("idle_after_rst_req", dmem.dmem_req, 0);
      chk("idle_after_rst_stall", stall_mem, 0);
      @(posedge clk); #2;
    end
`ifdef MEM_ACCESS_TIMEOUT_EN
    issue(1, 1, 0, 1, 2, 0, 32'h6000, $urandom, $urandom, 1000);
`endif
    for (int i = 0; i < 200; i++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 3);
      a = $urandom;
      case (op)
        0: issue(1, 1, 0, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom, $urandom_range(0, 3));
        1: issue(1, 1'($urandom), 1, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom, $urandom_range(0, 3));
        2: issue(1, 0, 0, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom, 0);
        default: issue(0, 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom, 0);
      endcase
    end
    in_valid = 1'b0;
    @(negedge clk); #2;
    chk("wb_pending", wq.size(), 0);
    chk("req_pending", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
